board_fill_responder: RTL and testbench
=======================================

Name: board_fill_responder

Overview:
- Responder side of the new-board request/ready handshake issued by the selector.
- On a request, generates a random SIZE x SIZE board of colours in 0..COLOR_NUM-1.
- Streams the board one cell per accepted cycle through a write port into the board storage.
- Raises READY when the board is complete; the game-start gate consumes READY.

Parameters:
- MAX_SIZE, 26, largest board edge; SIZE is clamped to this.
- COLOR_W, 3, width of a cell colour code.
- LFSR_W, 16, width of the pseudo-random generator.
- DEFAULT_SEED, 16'hACE1, substituted whenever the computed seed is zero.

Ports:
- CLOCK  in  1  single clock for the block.
- RESET  in  1  asynchronous reset, active-high.
- SEED  in  16  external entropy, XORed into the seed.
- NEW_BOARD  in  1  request level from the selector.
- SIZE  in  5  requested board edge.
- COLOR_NUM  in  4  requested number of colours.
- WR_EN  out  1  cell write strobe.
- WR_ROW  out  5  cell row.
- WR_COL  out  5  cell column.
- WR_COLOR  out  3  cell colour.
- BUSY  out  1  high while seeding or filling.
- READY  out  1  board complete and valid.

Behaviour:
- Reset (async) values: state IDLE; all outputs 0; LFSR = DEFAULT_SEED; free-running 16-bit counter = 0; request-edge register = 0.
- States are IDLE, SEED, FILL and DONE.
- IDLE -> SEED on a NEW_BOARD rising edge (registered compare of NEW_BOARD).
  - Latch SIZE, clamped to 2..MAX_SIZE.
  - Latch COLOR_NUM, clamped to 2..8.
  - In the same cycle: READY <= 0, BUSY <= 1.
- SEED (one cycle):
  - LFSR <= SEED ^ counter, or DEFAULT_SEED if that value is 0.
  - Row and column <= 0.
  - Go to FILL.
- FILL, every cycle:
  - Advance the Galois LFSR one step. The polynomial is x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Candidate = LFSR[2:0] before the step.
  - If candidate < COLOR_NUM (the latched value): WR_EN=1, WR_ROW/WR_COL = current position, WR_COLOR = candidate. Then advance the column; on column = SIZE-1, wrap the column to 0 and increment the row.
  - Otherwise (rejected): WR_EN=0 and the position holds.
  - After the write to (SIZE-1, SIZE-1), go to DONE.
- DONE:
  - Registered READY=1 and BUSY=0 on the cycle after the last write.
  - READY holds until the next NEW_BOARD rising edge.
- WR_* outputs are registered. WR_ROW/WR_COL/WR_COLOR hold their last values when WR_EN=0.
- Latency: the first write is visible two cycles after the edge that samples the request. With COLOR_NUM=8 the fill takes exactly SIZE*SIZE cycles.
- A rising edge during SEED or FILL is ignored; the fill in progress completes.
- NEW_BOARD deasserting mid-fill does not abort the fill.
- A rising edge in DONE starts a new fill, with READY dropping immediately.
- RESET mid-fill returns to IDLE with READY=0; the partial board is invalid.
- The counter free-runs in all states and wraps at 16'hFFFF -> 0.

Optional Feature:
- Macro NO_H_REPEAT_EN.
- When defined:
  - A candidate equal to the previously written colour in the same row is also rejected.
  - Column 0 is never rejected on this rule.
  - The last colour is registered per row.
- When undefined: only the range rejection applies, and adjacent repeats are allowed.

Decomposition:
- Shared package floodit_pkg holds:
  - COLOR_W and MAX_SIZE.
  - LFSR mask 16'hB400 and DEFAULT_SEED.
  - The fill state enum (IDLE, SEED, FILL, DONE).
  - Colour codes: 0 red, 1 green, 2 blue, 3 yellow.
- One sub-module, lfsr16, provides:
  - Inputs: load, load value, step enable.
  - Output: current state.
- Clamping, the position counters and the FSM stay in board_fill_responder.

Test Plan:
- Basic fill:
  - Stimulus: reset, SEED=0, raise NEW_BOARD at cycle 5 (counter=5), SIZE=4, COLOR_NUM=8.
  - Required: LFSR loaded with 16'h0005; exactly 16 WR_EN pulses in 16 consecutive cycles, row-major (0,0)..(3,3); READY=1 one cycle after (3,3); colours match a reference model.
- Range rejection:
  - Stimulus: COLOR_NUM=3, SIZE=6.
  - Required: every WR_COLOR is in 0..2; the count of WR_EN pulses is 36; each gap cycle corresponds to a model candidate >= 3.
- Clamping:
  - Stimulus 1: SIZE=31, COLOR_NUM=0. Required: 26x26 = 676 writes, colours in 0..1.
  - Stimulus 2: SIZE=1. Required: 4 writes.
- Zero seed:
  - Stimulus: SEED equal to the counter value at request.
  - Required: LFSR loads 16'hACE1 and the fill completes normally.
- Mid-operation events:
  - Stimulus 1: re-pulse NEW_BOARD during FILL. Required: no restart.
  - Stimulus 2: assert RESET at write 7. Required: all outputs 0 asynchronously; IDLE; a new request produces a full fill.
  - Stimulus 3: raise NEW_BOARD in DONE. Required: READY falls on the next cycle.
- NO_H_REPEAT_EN:
  - Stimulus: macro defined, SIZE=8, COLOR_NUM=2.
  - Required: every row alternates colours, with no adjacent equal pair in any row.

Source files
------------

// File: rtl/floodit_pkg.sv
// ---------------------------------------------------------------------------
// floodit_pkg
// Shared definitions for the board generator: board/colour sizing, the
// pseudo-random generator constants, the fill state encoding and the named
// colour codes.
// lfsr_next() performs one right-shifting Galois step of the polynomial
// x^16+x^14+x^13+x^11+1 (tap mask 16'hB400).
// ---------------------------------------------------------------------------
package floodit_pkg;

    localparam int          COLOR_W      = 3;
    localparam int          MAX_SIZE     = 26;
    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } fill_state_t;

    typedef enum logic [2:0] {
        COLOR_RED    = 3'd0,
        COLOR_GREEN  = 3'd1,
        COLOR_BLUE   = 3'd2,
        COLOR_YELLOW = 3'd3
    } color_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/board_fill_responder_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR with synchronous load and step enable.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high (state <= RESET_VALUE)
//   load_i       load load_value_i this cycle (takes priority over step)
//   load_value_i value to load
//   step_i       advance one Galois step this cycle
//   state_o      current generator state
// ---------------------------------------------------------------------------
module lfsr16
    import floodit_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = floodit_pkg::DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] load_value_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_value_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/board_fill_responder.sv
// ---------------------------------------------------------------------------
// board_fill_responder
// Answers a new-board request by generating a random SIZE x SIZE board of
// colours 0..COLOR_NUM-1 and streaming it, one cell per accepted cycle and in
// row-major order, into the board storage. READY is raised once the last
// cell has been written and held until the next request edge.
//
// Ports:
//   CLOCK      clock
//   RESET      asynchronous reset, active-high
//   SEED       external entropy, XORed with the free-running counter
//   NEW_BOARD  request level; a rising edge starts a fill (IDLE or DONE)
//   SIZE       requested board edge, clamped to 2..MAX_SIZE
//   COLOR_NUM  requested colour count, clamped to 2..8
//   WR_EN      cell write strobe (registered)
//   WR_ROW     cell row (holds when WR_EN=0)
//   WR_COL     cell column (holds when WR_EN=0)
//   WR_COLOR   cell colour (holds when WR_EN=0)
//   BUSY       high while seeding or filling
//   READY      board complete and valid
//
// Build option: define NO_H_REPEAT_EN to also reject a candidate equal to
// the colour previously written in the same row (column 0 exempt).
// ---------------------------------------------------------------------------
module board_fill_responder
    import floodit_pkg::*;
#(
    parameter int          MAX_SIZE     = floodit_pkg::MAX_SIZE,
    parameter int          COLOR_W      = floodit_pkg::COLOR_W,
    parameter int          LFSR_W       = floodit_pkg::LFSR_W,
    parameter logic [15:0] DEFAULT_SEED = floodit_pkg::DEFAULT_SEED
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [LFSR_W-1:0]  SEED,
    input  logic               NEW_BOARD,
    input  logic [4:0]         SIZE,
    input  logic [3:0]         COLOR_NUM,
    output logic               WR_EN,
    output logic [4:0]         WR_ROW,
    output logic [4:0]         WR_COL,
    output logic [COLOR_W-1:0] WR_COLOR,
    output logic               BUSY,
    output logic               READY
);

    fill_state_t        state_q, state_d;
    logic [15:0]        cnt_q;
    logic               req_q;
    logic [15:0]        cnt_cap_q, cnt_cap_d;
    logic [4:0]         size_q, size_d;
    logic [3:0]         ncol_q, ncol_d;
    logic [4:0]         row_q, row_d;
    logic [4:0]         col_q, col_d;
    logic               wr_en_q, wr_en_d;
    logic [4:0]         wr_row_q, wr_row_d;
    logic [4:0]         wr_col_q, wr_col_d;
    logic [COLOR_W-1:0] wr_color_q, wr_color_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic               req_rise;
    logic [4:0]         size_clamped;
    logic [3:0]         ncol_clamped;
    logic [15:0]        seed_mix;
    logic [15:0]        seed_value;
    logic               lfsr_load;
    logic               lfsr_step;
    logic [15:0]        lfsr_state;
    logic [COLOR_W-1:0] candidate;
    logic [15:COLOR_W]  lfsr_tap_unused;
    logic               accept;

    lfsr16 #(
        .RESET_VALUE (DEFAULT_SEED)
    ) u_lfsr (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .load_i       (lfsr_load),
        .load_value_i (seed_value),
        .step_i       (lfsr_step),
        .state_o      (lfsr_state)
    );

    // Only the low bits form the colour candidate.
    assign candidate       = lfsr_state[COLOR_W-1:0];
    assign lfsr_tap_unused = lfsr_state[15:COLOR_W];

    assign req_rise = NEW_BOARD & ~req_q;

    assign size_clamped = (SIZE < 5'd2)              ? 5'd2 :
                          (SIZE > 5'(MAX_SIZE))      ? 5'(MAX_SIZE) : SIZE;
    assign ncol_clamped = (COLOR_NUM < 4'd2) ? 4'd2 :
                          (COLOR_NUM > 4'd8) ? 4'd8 : COLOR_NUM;

    // The counter value is captured on the request edge, so the seed depends
    // on when the request arrived rather than on the fixed SEED-state delay.
    assign seed_mix   = 16'(SEED) ^ cnt_cap_q;
    assign seed_value = (seed_mix == 16'd0) ? DEFAULT_SEED : seed_mix;

`ifdef NO_H_REPEAT_EN
    logic [COLOR_W-1:0] last_color_q, last_color_d;

    // Column 0 starts a row, so there is no left neighbour to repeat.
    assign accept = (4'(candidate) < ncol_q) &&
                    ((col_q == 5'd0) || (candidate != last_color_q));

    always_comb begin
        last_color_d = last_color_q;
        if (state_q == S_FILL && accept) begin
            last_color_d = candidate;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            last_color_q <= '0;
        end else begin
            last_color_q <= last_color_d;
        end
    end
`else
    assign accept = (4'(candidate) < ncol_q);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_cap_d  = cnt_cap_q;
        size_d     = size_q;
        ncol_d     = ncol_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_color_d = wr_color_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
                if (req_rise) begin
                    state_d   = S_SEED;
                    size_d    = size_clamped;
                    ncol_d    = ncol_clamped;
                    cnt_cap_d = cnt_q;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_SEED: begin
                lfsr_load = 1'b1;
                row_d     = 5'd0;
                col_d     = 5'd0;
                state_d   = S_FILL;
            end
            S_FILL: begin
                lfsr_step = 1'b1;
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_row_d   = row_q;
                    wr_col_d   = col_q;
                    wr_color_d = candidate;
                    if (col_q == size_q - 5'd1) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                        if (row_q == size_q - 5'd1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            req_q      <= 1'b0;
            cnt_cap_q  <= 16'd0;
            size_q     <= 5'd0;
            ncol_q     <= 4'd0;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= 5'd0;
            wr_col_q   <= 5'd0;
            wr_color_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_q + 16'd1;
            req_q      <= NEW_BOARD;
            cnt_cap_q  <= cnt_cap_d;
            size_q     <= size_d;
            ncol_q     <= ncol_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_color_q <= wr_color_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign WR_EN    = wr_en_q;
    assign WR_ROW   = wr_row_q;
    assign WR_COL   = wr_col_q;
    assign WR_COLOR = wr_color_q;
    assign BUSY     = busy_q;
    assign READY    = ready_q;

endmodule

// File: tb/tb_board_fill_responder.sv
// ---------------------------------------------------------------------------
// tb_board_fill_responder
// Scoreboard bench: for each board request a reference model of the
// generator pushes one expected output record per fill cycle into a queue;
// every cycle the DUT outputs are popped against it.
// ---------------------------------------------------------------------------
module tb_board_fill_responder;

    typedef struct packed {
        logic       en;
        logic [4:0] row;
        logic [4:0] col;
        logic [2:0] color;
    } wr_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] SEED = 16'h0;
    logic        NEW_BOARD = 1'b0;
    logic [4:0]  SIZE = 5'd0;
    logic [3:0]  COLOR_NUM = 4'd0;
    logic        WR_EN;
    logic [4:0]  WR_ROW;
    logic [4:0]  WR_COL;
    logic [2:0]  WR_COLOR;
    logic        BUSY;
    logic        READY;

    board_fill_responder dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .SEED      (SEED),
        .NEW_BOARD (NEW_BOARD),
        .SIZE      (SIZE),
        .COLOR_NUM (COLOR_NUM),
        .WR_EN     (WR_EN),
        .WR_ROW    (WR_ROW),
        .WR_COL    (WR_COL),
        .WR_COLOR  (WR_COLOR),
        .BUSY      (BUSY),
        .READY     (READY)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference free-running counter.
    logic [15:0] tb_cnt;
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) tb_cnt <= 16'd0;
        else       tb_cnt <= tb_cnt + 16'd1;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  exp_q[$];
    logic [4:0] h_row = 5'd0;
    logic [4:0] h_col = 5'd0;
    logic [2:0] h_color = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Called and returns at a negedge. repulse_at/abort_at = 0 disables.
    task automatic do_fill(input int sz_req, input int nc_req, input logic [15:0] seed_in,
                           input bit zero_seed, input int repulse_at, input int abort_at);
        int          sz, nc, r, c, step, writes, bad_color, adj;
        logic [15:0] s, lf;
        logic [2:0]  cand, prev, prev_obs;
        bit          ok, last;
        wr_t         e;

        sz = (sz_req < 2) ? 2 : (sz_req > 26) ? 26 : sz_req;
        nc = (nc_req < 2) ? 2 : (nc_req > 8) ? 8 : nc_req;

        SIZE      = 5'(sz_req);
        COLOR_NUM = 4'(nc_req);
        SEED      = zero_seed ? tb_cnt : seed_in;
        s         = SEED ^ tb_cnt;
        if (s == 16'd0) s = 16'hACE1;
        NEW_BOARD = 1'b1;

        // Reference model: one record per FILL cycle.
        lf = s; r = 0; c = 0; prev = 3'd0; last = 1'b0;
        while (!last) begin
            cand = lf[2:0];
            ok   = (int'(cand) < nc);
`ifdef NO_H_REPEAT_EN
            if (c != 0 && cand == prev) ok = 1'b0;
`endif
            if (ok) begin
                h_row = 5'(r); h_col = 5'(c); h_color = cand;
                prev  = cand;
                last  = (r == sz - 1) && (c == sz - 1);
                if (c == sz - 1) begin c = 0; r++; end
                else c++;
                e.en = 1'b1;
            end else begin
                e.en = 1'b0;
            end
            e.row = h_row; e.col = h_col; e.color = h_color;
            exp_q.push_back(e);
            lf = galois(lf);
        end

        @(negedge CLOCK);
        check("req_accept", {BUSY, READY, WR_EN}, 3'b100);
        NEW_BOARD = 1'b0;
        @(negedge CLOCK);
        check("seed_cycle", {BUSY, READY, WR_EN}, 3'b100);

        step = 0; writes = 0; bad_color = 0; adj = 0; prev_obs = 3'd0;
        while (exp_q.size() > 0) begin
            @(negedge CLOCK);
            step++;
            if (repulse_at > 0 && step == repulse_at)     NEW_BOARD = 1'b1;
            if (repulse_at > 0 && step == repulse_at + 2) NEW_BOARD = 1'b0;
            e = exp_q.pop_front();
            check("cell", {BUSY, READY, WR_EN, WR_ROW, WR_COL, WR_COLOR}, {2'b10, e});
            if (WR_EN === 1'b1) begin
                writes++;
                if (int'(WR_COLOR) >= nc) bad_color++;
                if (WR_COL != 5'd0 && WR_COLOR == prev_obs) adj++;
                prev_obs = WR_COLOR;
            end
            if (abort_at > 0 && writes == abort_at) begin
                RESET = 1'b1;
                #1;
                check("async_reset", {BUSY, READY, WR_EN, WR_ROW, WR_COL, WR_COLOR}, 16'h0);
                exp_q.delete();
                h_row = 5'd0; h_col = 5'd0; h_color = 3'd0;
                NEW_BOARD = 1'b0;
                repeat (2) @(negedge CLOCK);
                check("reset_hold", {BUSY, READY, WR_EN, WR_ROW, WR_COL, WR_COLOR}, 16'h0);
                RESET = 1'b0;
                repeat (2) @(negedge CLOCK);
                check("idle_after_reset", {BUSY, READY, WR_EN}, 3'b000);
                $display("[TB] fill size=%0d colors=%0d aborted by reset after %0d writes",
                         sz, nc, writes);
                return;
            end
        end

        @(negedge CLOCK);
        check("done", {BUSY, READY, WR_EN}, 3'b010);
        check("write_count", writes, sz * sz);
        check("color_range", bad_color, 0);
`ifdef NO_H_REPEAT_EN
        check("adjacent_repeat", adj, 0);
`endif
        $display("[TB] fill size=%0d colors=%0d seed=%04h writes=%0d cycles=%0d adj=%0d",
                 sz, nc, s, writes, step, adj);
    endtask

    initial begin
        int guard;

        repeat (3) @(negedge CLOCK);
        check("reset_state", {BUSY, READY, WR_EN, WR_ROW, WR_COL, WR_COLOR}, 16'h0);
        RESET = 1'b0;

        // Basic fill: request driven while the counter reads 5.
        guard = 0;
        while (tb_cnt != 16'd5 && guard < 100) begin
            @(negedge CLOCK);
            guard++;
        end
        check("counter_reach", tb_cnt, 16'd5);
        do_fill(4, 8, 16'h0000, 1'b0, 0, 0);

        // READY holds in DONE without a new edge.
        repeat (3) @(negedge CLOCK);
        check("ready_hold", {BUSY, READY}, 2'b01);

        // Range rejection; request from DONE also checks READY falling.
        do_fill(6, 3, 16'h1234, 1'b0, 0, 0);
        // Clamping, large and small.
        do_fill(31, 0, 16'hBEEF, 1'b0, 0, 0);
        do_fill(1, 5, 16'h0F0F, 1'b0, 0, 0);
        // Zero seed substitution.
        do_fill(5, 8, 16'h0000, 1'b1, 0, 0);
        // Re-pulse during FILL must not restart.
        do_fill(5, 6, 16'h5A5A, 1'b0, 4, 0);
        // Reset at write 7, then a full fill.
        do_fill(6, 8, 16'h7777, 1'b0, 0, 7);
        do_fill(4, 8, 16'h2468, 1'b0, 0, 0);
        // Two colours on an 8x8 board.
        do_fill(8, 2, 16'hC0DE, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
